// File: rtl/draw_sched_pkg.sv
// Shared definitions for the sprite draw scheduler.
// Contents: pixel field widths, default erase colour and the scheduler state encoding.
package draw_sched_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BG_COLOUR_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_START,
        ST_WAIT
    } sched_state_t;

endpackage

// File: rtl/sched_watchdog.sv
// Per-pass WAIT watchdog for the sprite draw scheduler (used when SCHED_TIMEOUT_EN is defined).
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   clear         : restart the count at 0
//   enable        : count this cycle
//   expired       : high in the TIMEOUT_CYCLES-th enabled cycle since the last clear
module sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // count is 0 in the first enabled cycle, so expiry at TIMEOUT_CYCLES-1
    // bounds a pass to exactly TIMEOUT_CYCLES waiting cycles.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Sprite draw scheduler: time-shares one VGA pixel port between NUM_SPRITES drawers.
// Each frame visits every enabled slot in order and runs an erase pass (BG_COLOUR at
// the previous position) followed by a draw pass.
// Optional feature: define SCHED_TIMEOUT_EN to bound each WAIT pass to TIMEOUT_CYCLES.
// Ports:
//   clock, resetn                      : clock, asynchronous active-low reset
//   frame_tick                         : request a redraw of all sprites
//   sprite_en/x/y/colour/done          : per-drawer enable, pixel, colour, idle flag
//   start                              : one-hot restart pulse to a drawer
//   erase                              : current pass is an erase pass
//   vga_x, vga_y, vga_colour, vga_plot : muxed pixel write to the VGA adapter
//   busy, frame_done                   : frame in progress / last slot completed
//   frame_overrun, timeout_err         : sticky error flags
module sprite_draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int unsigned          NUM_SPRITES    = 7,
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR      = BG_COLOUR_DEFAULT
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            frame_tick,
    input  logic [NUM_SPRITES-1:0]          sprite_en,
    input  logic [X_W*NUM_SPRITES-1:0]      sprite_x,
    input  logic [Y_W*NUM_SPRITES-1:0]      sprite_y,
    input  logic [COLOUR_W*NUM_SPRITES-1:0] sprite_colour,
    input  logic [NUM_SPRITES-1:0]          sprite_done,
    output logic [NUM_SPRITES-1:0]          start,
    output logic                            erase,
    output logic [X_W-1:0]                  vga_x,
    output logic [Y_W-1:0]                  vga_y,
    output logic [COLOUR_W-1:0]             vga_colour,
    output logic                            vga_plot,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            frame_overrun,
    output logic                            timeout_err
);

    // idx also takes the value NUM_SPRITES: that is the "past last slot" scan
    // cycle which ends the frame, giving an empty frame NUM_SPRITES+1 cycles.
    localparam int unsigned IDX_W = $clog2(NUM_SPRITES + 1);

    sched_state_t     state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             erase_n;
    logic             slot_valid;
    logic [IDX_W-1:0] sel;
    logic             pass_done;

    assign slot_valid = (idx < IDX_W'(NUM_SPRITES));
    assign sel        = slot_valid ? idx : '0;

`ifdef SCHED_TIMEOUT_EN
    logic wd_expired;

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    assign pass_done = sprite_done[sel] | wd_expired;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else if ((state == ST_WAIT) && wd_expired && !sprite_done[sel]) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign pass_done      = sprite_done[sel];
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
            erase <= 1'b1;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            erase <= erase_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        erase_n    = erase;
        start      = '0;
        frame_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_n = ST_SCAN;
                    idx_n   = '0;
                    erase_n = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!slot_valid) begin
                    state_n    = ST_IDLE;
                    frame_done = 1'b1;
                end else if (sprite_en[sel]) begin
                    state_n = ST_START;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            ST_START: begin
                start[sel] = 1'b1;
                state_n    = ST_WAIT;
            end
            ST_WAIT: begin
                // The enable is not re-checked here, so a started slot always
                // finishes both passes.
                if (pass_done) begin
                    if (erase) begin
                        erase_n = 1'b0;
                        state_n = ST_START;
                    end else begin
                        erase_n = 1'b1;
                        idx_n   = idx + 1'b1;
                        state_n = ST_SCAN;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_overrun <= 1'b0;
        end else if (frame_tick && (state != ST_IDLE)) begin
            frame_overrun <= 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign vga_plot   = (state == ST_WAIT) && !sprite_done[sel];
    assign vga_x      = sprite_x[sel*X_W +: X_W];
    assign vga_y      = sprite_y[sel*Y_W +: Y_W];
    assign vga_colour = erase ? BG_COLOUR : sprite_colour[sel*COLOUR_W +: COLOUR_W];

endmodule
